// File: rtl/uart_word_tx.sv
// Word-oriented 8N1 UART transmitter with a small word FIFO.
// Each 32-bit word leaves as four bytes, least-significant byte first.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        tx,
    output logic        busy,
    output logic [15:0] words_sent
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = AW + 1;
    localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0]   CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [31:0]     shreg_q, shreg_d;
    logic [1:0]      byte_q, byte_d;
    logic [2:0]      bit_q, bit_d;
    logic [CW-1:0]   clk_q, clk_d;
    logic            tx_q, tx_d;
    logic [15:0]     sent_q, sent_d;

    logic       push;
    logic       pop;
    logic       empty;
    logic       full;
    logic       bit_done;
    logic [7:0] cur_byte;

    assign full       = (cnt_q == FULL_CNT);
    assign empty      = (cnt_q == '0);
    assign word_ready = !full;
    assign push       = word_valid && !full;
    assign bit_done   = (clk_q == CLK_LAST);
    assign cur_byte   = shreg_q[7:0];

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign words_sent = sent_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        clk_d   = clk_q;
        tx_d    = tx_q;
        sent_d  = sent_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rptr_q];
                    byte_d  = '0;
                    bit_d   = '0;
                    clk_d   = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    clk_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    clk_d = clk_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    clk_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_d];
                    end
                end else begin
                    clk_d = clk_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    clk_d = '0;
                    bit_d = '0;
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        shreg_d = {8'h00, shreg_q[31:8]};
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        sent_d = sent_q + 16'd1;
                        // Chain straight into the next word's start bit.
                        if (!empty) begin
                            pop     = 1'b1;
                            shreg_d = mem_q[rptr_q];
                            byte_d  = '0;
                            state_d = START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end
                end else begin
                    clk_d = clk_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            clk_q   <= '0;
            tx_q    <= 1'b1;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            clk_q   <= clk_d;
            tx_q    <= tx_d;
            sent_q  <= sent_d;
        end
    end

    // Storage needs no reset: the count register alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= word_in;
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: serial-line decoder with a word scoreboard
// plus directed timing checks from the stimulus thread.
module tb_uart_word_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int MID   = CPB / 2 - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        tx;
    logic        busy;
    logic [15:0] words_sent;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_sent = 0;

    logic [31:0] expq [$];
    logic [7:0]  rx_bytes [$];

    uart_word_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .word_in   (word_in),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .tx        (tx),
        .busy      (busy),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 0);
        repeat (4) tick();
    endtask

    // Serial decoder: samples mid-bit on falling clock edges.
    task automatic rx_byte(output bit ok, output logic [7:0] b);
        ok = 1'b1;
        b  = '0;
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? MID : CPB) begin
                @(negedge clk);
                if (rst) ok = 1'b0;
            end
            if (!ok) return;
            if (i == 0) chk("start_bit", tx, 0);
            else if (i == 9) chk("stop_bit", tx, 1);
            else b[i-1] = tx;
        end
    endtask

    int          mbi = 0;
    logic [31:0] mword = '0;
    logic [7:0]  rb;
    logic [31:0] ew;
    bit          rok;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                mbi = 0;
            end else if (tx === 1'b0) begin
                rx_byte(rok, rb);
                if (!rok) begin
                    mbi = 0;
                end else begin
                    rx_bytes.push_back(rb);
                    mword[8*mbi +: 8] = rb;
                    mbi++;
                    if (mbi == 4) begin
                        mbi = 0;
                        if (expq.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_word: got %h expected none", mword);
                        end else begin
                            ew = expq.pop_front();
                            chk("word", mword, ew);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int bcnt;
        int k;
        bit r;
        bit all_high;
        logic [7:0] eb;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", word_ready, 1);
        chk("rst_sent", words_sent, 0);
        #2 rst = 1'b0;
        repeat (2) tick();

        // Single word 0x0000000E: timing of start bit, data and completion
        word_in = 32'h0000_000E;
        word_valid = 1'b1;
        expq.push_back(word_in);
        tick();
        word_valid = 1'b0;
        chk("t1_busy_e0", busy, 0);
        chk("t1_tx_e0", tx, 1);
        tick();
        chk("t1_tx_e1", tx, 0);
        chk("t1_busy_e1", busy, 1);
        repeat (3) tick();
        chk("t1_tx_e4", tx, 0);
        repeat (5) tick();
        chk("t1_tx_e9", tx, 1);
        repeat (151) tick();
        chk("t1_sent_e160", words_sent, 0);
        chk("t1_busy_e160", busy, 1);
        tick();
        chk("t1_sent_e161", words_sent, 1);
        chk("t1_busy_e161", busy, 0);
        exp_sent = 1;
        chk("t1_drained", 32'(expq.size()), 0);
        repeat (4) tick();

        // Byte order
        rx_bytes.delete();
        word_in = 32'hA1B2_C3D4;
        word_valid = 1'b1;
        expq.push_back(word_in);
        tick();
        word_valid = 1'b0;
        tick();
        wait_idle(1000);
        exp_sent += 1;
        chk("t2_nbytes", 32'(rx_bytes.size()), 4);
        for (int i = 0; i < 4 && i < rx_bytes.size(); i++) begin
            case (i)
                0: eb = 8'hD4;
                1: eb = 8'hC3;
                2: eb = 8'hB2;
                default: eb = 8'hA1;
            endcase
            chk("t2_byte", rx_bytes[i], eb);
        end
        chk("t2_sent", words_sent, 32'(exp_sent));

        // Back-to-back words: busy must span exactly 3 x 160 cycles
        bcnt = 0;
        word_valid = 1'b1;
        word_in = 32'h0123_4567;
        expq.push_back(word_in);
        tick();
        if (busy) bcnt++;
        word_in = 32'hFEDC_BA98;
        expq.push_back(word_in);
        tick();
        if (busy) bcnt++;
        word_in = 32'h55AA_00FF;
        expq.push_back(word_in);
        tick();
        if (busy) bcnt++;
        word_valid = 1'b0;
        for (int i = 0; i < 2000 && busy; i++) begin
            tick();
            if (busy) bcnt++;
        end
        chk("t3_busy_len", bcnt, 480);
        exp_sent += 3;
        chk("t3_sent", words_sent, 32'(exp_sent));
        chk("t3_drained", 32'(expq.size()), 0);
        repeat (4) tick();

        // Backpressure, then a push landing right after the pop frees a slot
        k = 0;
        word_in = 32'h1000_0000;
        word_valid = 1'b1;
        for (int c = 0; c < 2000 && k < 6; c++) begin
            r = word_ready;
            tick();
            if (r) begin
                expq.push_back(word_in);
                k++;
                word_in = 32'h1000_0000 + 32'(k);
            end
            if (c == 3) chk("t4_ready_e3", word_ready, 1);
            if (c == 4) begin
                chk("t4_ready_e4", word_ready, 0);
                chk("t4_accepted", k, 5);
            end
            if (c == 160) chk("t4_ready_e160", word_ready, 0);
            if (c == 161) chk("t4_ready_e161", word_ready, 1);
            if (c == 162) chk("t4_ready_e162", word_ready, 0);
        end
        word_valid = 1'b0;
        chk("t4_total", k, 6);
        wait_idle(2000);
        exp_sent += 6;
        chk("t4_sent", words_sent, 32'(exp_sent));
        chk("t4_drained", 32'(expq.size()), 0);

        // Reset during DATA of byte 1 with two words queued
        word_valid = 1'b1;
        word_in = 32'h0000_0000;
        expq.push_back(word_in);
        tick();
        word_in = 32'h1234_5678;
        expq.push_back(word_in);
        tick();
        word_in = 32'h9ABC_DEF0;
        expq.push_back(word_in);
        tick();
        word_valid = 1'b0;
        repeat (53) tick();
        chk("t5_tx_pre", tx, 0);
        chk("t5_sent_pre", words_sent, 32'(exp_sent));
        #2;
        rst = 1'b1;
        expq.delete();
        #1;
        chk("t5_tx_rst", tx, 1);
        chk("t5_busy_rst", busy, 0);
        chk("t5_sent_rst", words_sent, 0);
        chk("t5_ready_rst", word_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        all_high = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (tx !== 1'b1) all_high = 1'b0;
        end
        chk("t5_tx_quiet", all_high, 1);
        chk("t5_busy_after", busy, 0);
        chk("t5_sent_after", words_sent, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
